// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. One full adder processes the operands LSB
//   first, one bit per clock, so a WIDTH-bit operation takes WIDTH cycles.
//   Subtraction is a + ~b + 1: b is inverted on capture and the carry flop
//   is preloaded with 1.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//
// Ports
//   clock      sole clock, rising edge
//   clear      asynchronous active-high reset
//   start      request; accepted only when not shifting
//   sub        mode captured with start: 0 = a+b, 1 = a-b
//   a, b       operands, captured with start
//   sum        registered result, held until the next completion
//   carry_out  final carry; in subtract mode 1 = no borrow (a >= b unsigned)
//   overflow   two's-complement overflow of the last completed operation
//   busy       high while bits are being shifted
//   done       single-cycle completion pulse
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             msb_cin_q;

    logic             accept;
    logic             shifting;
    logic             last_bit;
    logic             msb_next;
    logic             fa_sum;
    logic             fa_carry;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    assign shifting = (state_q == SHIFT);
    // start during SHIFT is ignored entirely
    assign accept   = start && !shifting;
    assign last_bit = shifting && (count_q == CW'(WIDTH - 1));
    // The adder carry out of bit WIDTH-2 is the carry into the MSB
    assign msb_next = shifting && (count_q == CW'(WIDTH - 2));

    // -----------------------------------------------------------------------
    // Single full adder on the operand LSBs
    // -----------------------------------------------------------------------
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Back-to-back operation when start is already waiting
                if (start) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Serial datapath: operand shift registers, carry flop, bit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            count_q <= '0;
        end else if (shifting) begin
            // Result bits fill A from the top as operand bits leave the bottom
            a_q     <= {fa_sum, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            carry_q <= fa_carry;
            count_q <= count_q + CW'(1);
        end
    end

    // Carry into the MSB, kept for the overflow decision at completion
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            msb_cin_q <= 1'b0;
        end else if (msb_next) begin
            msb_cin_q <= fa_carry;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: updated only on the final shift cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (last_bit) begin
            sum       <= {fa_sum, a_q[WIDTH-1:1]};
            carry_out <= fa_carry;
            overflow  <= msb_cin_q ^ fa_carry;
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs decoded from the state register
    // -----------------------------------------------------------------------
    assign busy = shifting;
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH = 8). Directed vectors plus
//   randomized operations, compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W = 8;

    logic         clock;
    logic         clear;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    int unsigned  n_checks;
    int unsigned  n_fail;

    // Last completed result, as expected by the model
    logic [W-1:0] prev_sum;
    logic         prev_co;
    logic         prev_ov;

    serial_addsub #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] es, output logic eco, output logic eov);
        int ua, ub, sa, sb, r;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        if (msub) begin
            es  = W'(ua - ub);
            eco = (ua >= ub);
            r   = sa - sb;
        end else begin
            es  = W'(ua + ub);
            eco = (ua + ub) >= (1 << W);
            r   = sa + sb;
        end
        eov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    // Called at a falling edge. Runs one full operation and checks every
    // cycle. With inject set, a new start is presented during SHIFT.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_sub, input bit inject);
        logic [W-1:0] es;
        logic         eco, eov;
        model(op_a, op_b, op_sub, es, eco, eov);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            check("busy_shift", busy, 1);
            check("done_shift", done, 0);
            check("sum_hold", sum, prev_sum);
            check("co_hold", carry_out, prev_co);
            check("ov_hold", overflow, prev_ov);
            if (inject && k == 2) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
            end
            if (inject && k == 3) begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", sum, es);
        check("carry_out", carry_out, eco);
        check("overflow", overflow, eov);
        prev_sum = es;
        prev_co  = eco;
        prev_ov  = eov;
    endtask

    initial begin
        int first_done, second_done, n_done;
        n_checks = 0;
        n_fail   = 0;
        prev_sum = '0;
        prev_co  = 1'b0;
        prev_ov  = 1'b0;
        clear    = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;

        repeat (2) @(negedge clock);
        check("rst_sum", sum, 0);
        check("rst_co", carry_out, 0);
        check("rst_ov", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // start is ignored while clear is high
        start = 1'b1;
        @(negedge clock);
        check("clr_start_busy", busy, 0);
        start = 1'b0;
        clear = 1'b0;
        @(negedge clock);

        // Directed vectors
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("v_5a3c_sum", sum, 8'h96);
        check("v_5a3c_co", carry_out, 0);
        check("v_5a3c_ov", overflow, 1);
        @(negedge clock);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check("v_ff01_sum", sum, 8'h00);
        check("v_ff01_co", carry_out, 1);
        check("v_ff01_ov", overflow, 0);
        do_op(8'h10, 8'h20, 1'b1, 1'b0);
        check("v_1020_sum", sum, 8'hF0);
        check("v_1020_co", carry_out, 0);
        check("v_1020_ov", overflow, 0);
        @(negedge clock);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        check("v_8001_sum", sum, 8'h7F);
        check("v_8001_co", carry_out, 1);
        check("v_8001_ov", overflow, 1);
        @(negedge clock);

        // start during SHIFT must be ignored
        do_op(8'h21, 8'h13, 1'b0, 1'b1);
        @(negedge clock);
        check("inject_idle_busy", busy, 0);
        check("inject_idle_done", done, 0);
        check("inject_idle_sum", sum, 8'h34);

        // start held high: back-to-back operations
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'h01;
        b     = 8'h01;
        @(posedge clock);
        @(negedge clock);
        a           = 8'h02;
        b           = 8'h02;
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        for (int k = 0; k < 2 * W + 4; k++) begin
            check("b2b_exclusive", busy & done, 0);
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    check("b2b_sum1", sum, 8'h02);
                end else begin
                    second_done = k;
                    check("b2b_sum2", sum, 8'h04);
                    start = 1'b0;
                end
            end
            @(negedge clock);
        end
        check("b2b_count", n_done, 2);
        check("b2b_first", first_done, W);
        check("b2b_gap", second_done - first_done, W + 1);
        prev_sum = 8'h04;
        prev_co  = 1'b0;
        prev_ov  = 1'b0;

        // clear mid-operation aborts
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h11;
        sub   = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_co", carry_out, 0);
        check("abort_ov", overflow, 0);
        @(negedge clock);
        clear = 1'b0;
        n_done = 0;
        for (int k = 0; k < W + 2; k++) begin
            if (done) n_done++;
            @(negedge clock);
        end
        check("abort_no_done", n_done, 0);
        prev_sum = '0;
        prev_co  = 1'b0;
        prev_ov  = 1'b0;
        do_op(8'h03, 8'h04, 1'b0, 1'b0);
        check("after_abort_sum", sum, 8'h07);

        // Randomized operations with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clock);
            do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
        end
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, is the operand/result width in bits; legal range 2..32.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high; one clock, reset asynchronous and active-high.
REQ-004 start  input  1  request; sampled on the rising edge of clock.
REQ-005 sub  input  1  mode captured with start: 0 = a+b, 1 = a-b.
REQ-006 a  input  WIDTH  minuend/augend, captured with start.
REQ-007 b  input  WIDTH  subtrahend/addend, captured with start.
REQ-008 sum  output  WIDTH  registered result, held until the next completion.
REQ-009 carry_out  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-010 overflow  output  1  two's-complement signed overflow of the last completed operation.
REQ-011 busy  output  1  high while bits are being shifted.
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; encoding is implementation-defined.
REQ-014 start is accepted only in IDLE or DONE; start in SHIFT is ignored with no side effect.
REQ-015 On accept: operand register A <= a; B <= sub ? ~b : b; carry flop <= sub; bit counter <= 0; state -> SHIFT.
REQ-016 Serial datapath: one full adder on A[0], B[0], carry flop; LSB first, one bit per cycle.
REQ-017 Each SHIFT cycle: A shifts right with the adder sum bit entering A[WIDTH-1]; B shifts right; carry flop <= adder carry; counter increments.
REQ-018 On the SHIFT cycle where counter == WIDTH-2, the carry into the MSB (the carry flop value entering the last bit) is captured for overflow.
REQ-019 After exactly WIDTH SHIFT cycles: state -> DONE; sum <= final A; carry_out <= final carry; overflow <= captured MSB carry-in XOR final carry.
REQ-020 Latency: done is high in the cycle beginning WIDTH rising edges after the accepting edge; busy is high for exactly WIDTH cycles starting the cycle after acceptance.
REQ-021 done is high only in DONE, for exactly one cycle; busy and done are never high together.
REQ-022 DONE -> IDLE on the next edge, or DONE -> SHIFT if start is high (back-to-back with zero idle cycles).
REQ-023 sum, carry_out and overflow change only at completion; they hold their values through IDLE and the following SHIFT.
REQ-024 Arithmetic is modulo 2^WIDTH; the result equals (a + b) or (a + ~b + 1) truncated to WIDTH bits.

Reset
REQ-025 clear high asynchronously forces: state IDLE; sum 0; carry_out 0; overflow 0; busy 0; done 0; A, B, carry flop and counter 0.
REQ-026 clear asserted mid-operation aborts the operation; no done pulse follows and outputs read reset values.
REQ-027 While clear is high, start is ignored; the first accept is possible on the first rising edge after clear falls.

Verification (WIDTH=8)
REQ-028 add 5A+3C -> done 8 cycles after accept; sum 96; carry_out 0; overflow 1.
REQ-029 add FF+01 -> sum 00; carry_out 1; overflow 0. sub 10-20 -> sum F0; carry_out 0; overflow 0.
REQ-030 sub 80-01 -> sum 7F; carry_out 1; overflow 1.
REQ-031 start pulsed with new operands at cycle 3 of SHIFT -> ignored; the result of the first operation is unchanged; busy is continuous for 8 cycles.
REQ-032 start held high continuously with 01+01 then 02+02 -> back-to-back done pulses 9 cycles apart; sums 02, then 04.
REQ-033 clear pulsed during cycle 4 of SHIFT -> busy 0 immediately; all outputs 0; no done pulse; a later 03+04 gives sum 07.
